tmp_i2c_responder: RTL and testbench

- Synthesizable I2C target that emulates the on-board TMP temperature sensor at the far end of the TMP_SCL/TMP_SDA bus.
- The design's I2C master and its display path can be exercised in simulation and in loopback without the physical part.
- Oversamples SCL/SDA on the system clock, decodes START/STOP, address, register-pointer writes and register reads, and drives SDA open-drain.
- Returns a temperature value supplied on a parallel port.

---
 rtl/tmp_i2c_pkg.sv | 38 +++
 rtl/i2c_line_cond.sv | 77 +++++++
 rtl/tmp_i2c_responder.sv | 186 ++++++++++++++++++
 tb/tb_tmp_i2c_responder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmp_i2c_pkg.sv
// Shared definitions for the TMP sensor I2C responder: FSM encodings, register map and helpers.
// Register reads are purely combinational from pointer, temperature snapshot and config.
package tmp_i2c_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_ADDR      = 4'd1;
  localparam state_t ST_ADDR_ACK  = 4'd2;
  localparam state_t ST_PTR       = 4'd3;
  localparam state_t ST_PTR_ACK   = 4'd4;
  localparam state_t ST_WDATA     = 4'd5;
  localparam state_t ST_WDATA_ACK = 4'd6;
  localparam state_t ST_RDATA     = 4'd7;
  localparam state_t ST_RDATA_ACK = 4'd8;

  localparam logic [7:0] REG_TEMP_MSB = 8'h00;
  localparam logic [7:0] REG_TEMP_LSB = 8'h01;
  localparam logic [7:0] REG_CFG      = 8'h03;
  localparam logic [7:0] REG_ID       = 8'h0B;
  localparam logic [7:0] ID_VALUE     = 8'hCB;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [7:0] reg_read(input logic [7:0] ptr, input logic [15:0] hold,
                                          input logic [7:0] cfg);
    case (ptr)
      REG_TEMP_MSB: return hold[15:8];
      REG_TEMP_LSB: return hold[7:0];
      REG_CFG:      return cfg;
      REG_ID:       return ID_VALUE;
      default:      return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioner: synchronizer, optional 3-sample majority filter (TMP_RESP_GLITCH_FILTER_EN),
// and SCL edge / START / STOP detection. Detect pulses are one system clock wide.
module i2c_line_cond
  import tmp_i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_s, sda_s, scl_c, sda_c, scl_p_q, sda_p_q;

  // Synchronizers reset to the idle-bus level so release of reset never looks like an edge pair.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

`ifdef TMP_RESP_GLITCH_FILTER_EN
  logic [1:0] scl_h_q, sda_h_q;
  logic       scl_f_q, sda_f_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_h_q <= 2'b11;
      sda_h_q <= 2'b11;
      scl_f_q <= 1'b1;
      sda_f_q <= 1'b1;
    end else begin
      scl_h_q <= {scl_h_q[0], scl_s};
      sda_h_q <= {sda_h_q[0], sda_s};
      scl_f_q <= maj3(scl_s, scl_h_q[0], scl_h_q[1]);
      sda_f_q <= maj3(sda_s, sda_h_q[0], sda_h_q[1]);
    end
  end

  assign scl_c = scl_f_q;
  assign sda_c = sda_f_q;
`else
  assign scl_c = scl_s;
  assign sda_c = sda_s;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_p_q <= scl_c;
      sda_p_q <= sda_c;
    end
  end

  assign sda_o      = sda_c;
  assign scl_rise_o = scl_c & ~scl_p_q;
  assign scl_fall_o = ~scl_c & scl_p_q;
  assign start_o    = scl_c & scl_p_q & sda_p_q & ~sda_c;
  assign stop_o     = scl_c & scl_p_q & ~sda_p_q & sda_c;

endmodule

// File: rtl/tmp_i2c_responder.sv
// I2C target emulating the TMP temperature sensor: pointer/config writes, snapshot-coherent reads.
// Optional glitch filter via TMP_RESP_GLITCH_FILTER_EN; no clock stretching, SDA driven open-drain.
module tmp_i2c_responder
  import tmp_i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR    = 7'h4B,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        CLK100MHZ,
  input  logic        reset_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [15:0] temp_in,
  output logic [7:0]  cfg_reg,
  output logic        busy,
  output logic        addr_hit
);

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_line_cond (
    .clk_i      (CLK100MHZ),
    .rst_n_i    (reset_n),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop)
  );

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  sh_q, sh_d;
  logic [7:0]  ptr_q, ptr_d, cfg_q, cfg_d, tx_q, tx_d;
  logic [15:0] hold_q, hold_d;
  logic        oe_q, oe_d, ack_q, ack_d, rw_q, rw_d, busy_q, busy_d;
  logic [7:0]  rx_byte, rd_byte;

  assign rx_byte = {sh_q, sda_s};
  assign rd_byte = reg_read(ptr_q, hold_q, cfg_q);

  // ack_q marks the second half of an ACK slot (target driving) or a master ACK seen in RDATA_ACK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    cfg_d   = cfg_q;
    tx_d    = tx_q;
    oe_d    = oe_q;
    ack_d   = ack_q;
    rw_d    = rw_q;
    busy_d  = busy_q;
    if (stop) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      ack_d   = 1'b0;
      busy_d  = 1'b0;
    end else if (start) begin
      state_d = ST_ADDR;
      cnt_d   = 4'd0;
      ack_d   = 1'b0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            sh_d  = rx_byte[6:0];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              ack_d = 1'b0;
              if (state_q == ST_ADDR) begin
                if (rx_byte[7:1] == I2C_ADDR) begin
                  state_d = ST_ADDR_ACK;
                  rw_d    = rx_byte[0];
                  if (rx_byte[0]) hold_d = temp_in;
                end else begin
                  state_d = ST_IDLE;
                end
              end else if (state_q == ST_PTR) begin
                ptr_d   = rx_byte;
                state_d = ST_PTR_ACK;
              end else begin
                if (ptr_q == REG_CFG) cfg_d = rx_byte;
                ptr_d   = ptr_q + 8'd1;
                state_d = ST_WDATA_ACK;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_q) begin
              oe_d  = 1'b1;
              ack_d = 1'b1;
            end else begin
              ack_d = 1'b0;
              cnt_d = 4'd0;
              oe_d  = 1'b0;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                state_d = ST_RDATA;
                oe_d    = ~rd_byte[7];
                tx_d    = {rd_byte[6:0], 1'b0};
              end else if (state_q == ST_ADDR_ACK) begin
                state_d = ST_PTR;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              ack_d   = 1'b0;
              state_d = ST_RDATA_ACK;
            end else begin
              oe_d = ~tx_q[7];
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ptr_d = ptr_q + 8'd1;
              ack_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (scl_fall && ack_q) begin
            ack_d   = 1'b0;
            cnt_d   = 4'd0;
            state_d = ST_RDATA;
            oe_d    = ~rd_byte[7];
            tx_d    = {rd_byte[6:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      sh_q    <= 7'd0;
      ptr_q   <= 8'h00;
      hold_q  <= 16'h0000;
      cfg_q   <= 8'h00;
      tx_q    <= 8'h00;
      oe_q    <= 1'b0;
      ack_q   <= 1'b0;
      rw_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      cfg_q   <= cfg_d;
      tx_q    <= tx_d;
      oe_q    <= oe_d;
      ack_q   <= ack_d;
      rw_q    <= rw_d;
      busy_q  <= busy_d;
    end
  end

  assign sda_oe   = oe_q;
  assign cfg_reg  = cfg_q;
  assign busy     = busy_q;
  assign addr_hit = (state_q == ST_ADDR) && scl_rise && (cnt_q == 4'd7) &&
                    (rx_byte[7:1] == I2C_ADDR);

endmodule

// File: tb/tb_tmp_i2c_responder.sv
// Bit-banged I2C master with a register-level reference model; results go through a scoreboard queue.
module tb_tmp_i2c_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        scl_m, sda_m, sda_line;
  logic        sda_oe, busy, addr_hit;
  logic [15:0] temp_in;
  logic [7:0]  cfg_reg;

  always #5 clk = ~clk;
  assign sda_line = sda_m & ~sda_oe;

  tmp_i2c_responder dut (
    .CLK100MHZ (clk),
    .reset_n   (reset_n),
    .scl_i     (scl_m),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .temp_in   (temp_in),
    .cfg_reg   (cfg_reg),
    .busy      (busy),
    .addr_hit  (addr_hit)
  );

  typedef struct {
    string       name;
    logic [15:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] obs_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          hit_cnt = 0;

  // Reference model state: pointer, config, snapshot and expected address matches.
  logic [7:0]  m_ptr  = 8'h00;
  logic [7:0]  m_cfg  = 8'h00;
  logic [15:0] m_hold = 16'h0000;
  int          m_hits = 0;

  always @(negedge clk) if (addr_hit) hit_cnt++;

  always @(negedge clk) begin
    if (obs_q.size() > 0) begin
      logic [15:0] o;
      exp_t        e;
      o = obs_q.pop_front();
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got %h, nothing expected", o);
      end else begin
        e = exp_q.pop_front();
        if (o !== e.val) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h", e.name, o, e.val);
        end
      end
    end
  end

  task automatic sb_expect(input string nm, input logic [15:0] v);
    exp_t e;
    e.name = nm;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic sb_observe(input logic [15:0] v);
    obs_q.push_back(v);
  endtask

  function automatic logic [7:0] m_reg(input logic [7:0] p);
    if (p == 8'h00) return m_hold[15:8];
    if (p == 8'h01) return m_hold[7:0];
    if (p == 8'h03) return m_cfg;
    if (p == 8'h0B) return 8'hCB;
    return 8'h00;
  endfunction

  function automatic logic [7:0] pick_ptr();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'h03;
      3: return 8'h0B;
      4: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start();
    sda_m = 1'b1; wt(8);
    scl_m = 1'b1; wt(8);
    sda_m = 1'b0; wt(8);
    scl_m = 1'b0; wt(8);
  endtask

  task automatic m_stop();
    sda_m = 1'b0; wt(8);
    scl_m = 1'b1; wt(8);
    sda_m = 1'b1; wt(8);
  endtask

  task automatic m_wbit(input logic b, input bit glitch);
    sda_m = b; wt(8);
    scl_m = 1'b1;
    if (glitch) begin
      wt(3); scl_m = 1'b0; wt(1); scl_m = 1'b1; wt(8);
    end else begin
      wt(8);
    end
    scl_m = 1'b0; wt(8);
  endtask

  task automatic m_rbit(output logic b);
    sda_m = 1'b1; wt(8);
    scl_m = 1'b1; wt(4);
    b = sda_line; wt(4);
    scl_m = 1'b0; wt(8);
  endtask

  task automatic m_wbyte(input logic [7:0] d, input logic exp_ack, input string nm, input int gl_bit);
    logic a;
    for (int i = 7; i >= 0; i--) m_wbit(d[i], (i == gl_bit));
    sb_expect(nm, {15'd0, exp_ack});
    m_rbit(a);
    sb_observe({15'd0, a});
  endtask

  task automatic m_rbyte(input logic [7:0] exp_v, input logic ack_bit, input string nm);
    logic [7:0] d;
    logic       b;
    sb_expect(nm, {8'd0, exp_v});
    for (int i = 7; i >= 0; i--) begin
      m_rbit(b);
      d[i] = b;
    end
    sb_observe({8'd0, d});
    m_wbit(ack_bit, 1'b0);
  endtask

  task automatic t_write(input logic [6:0] a, input logic [7:0] p, input int n,
                         input logic [7:0] d0, input logic [7:0] d1, input bit do_stop, input int gl);
    logic [7:0] d;
    bit         hit;
    hit = (a == 7'h4B);
    m_start();
    m_wbyte({a, 1'b0}, !hit, "addr_ack_w", -1);
    if (hit) begin
      m_hits++;
      m_wbyte(p, 1'b0, "ptr_ack", -1);
      m_ptr = p;
      for (int i = 0; i < n; i++) begin
        d = (i == 0) ? d0 : d1;
        m_wbyte(d, 1'b0, "data_ack", gl);
        if (m_ptr == 8'h03) m_cfg = d;
        m_ptr = m_ptr + 8'd1;
      end
    end else begin
      sb_expect("busy_after_miss", 16'd1); sb_observe({15'd0, busy});
      m_wbyte(p, 1'b1, "nack_after_miss", -1);
      sb_expect("oe_after_miss", 16'd0); sb_observe({15'd0, sda_oe});
    end
    sb_expect("cfg", {8'd0, m_cfg}); sb_observe({8'd0, cfg_reg});
    sb_expect("hits", m_hits[15:0]); sb_observe(hit_cnt[15:0]);
    if (do_stop) begin
      m_stop();
      sb_expect("busy_after_stop", 16'd0); sb_observe({15'd0, busy});
    end
  endtask

  task automatic t_read(input int n, input logic [15:0] t2);
    bit last;
    m_hold = temp_in;
    m_start();
    m_wbyte({7'h4B, 1'b1}, 1'b0, "addr_ack_r", -1);
    m_hits++;
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      m_rbyte(m_reg(m_ptr), last, "rd_byte");
      if (i == 0) temp_in = t2;
      if (!last) m_ptr = m_ptr + 8'd1;
    end
    sb_expect("oe_after_nack", 16'd0); sb_observe({15'd0, sda_oe});
    m_stop();
    sb_expect("busy_after_stop", 16'd0); sb_observe({15'd0, busy});
    sb_expect("hits", m_hits[15:0]); sb_observe(hit_cnt[15:0]);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic b;
    reset_n = 1'b0;
    scl_m   = 1'b1;
    sda_m   = 1'b1;
    temp_in = 16'h0C80;
    wt(3);
    sb_expect("rst_oe", 16'd0);   sb_observe({15'd0, sda_oe});
    sb_expect("rst_cfg", 16'd0);  sb_observe({8'd0, cfg_reg});
    sb_expect("rst_busy", 16'd0); sb_observe({15'd0, busy});
    sb_expect("rst_hit", 16'd0);  sb_observe({15'd0, addr_hit});
    reset_n = 1'b1;
    wt(5);

    // Config write, three ACKs.
    t_write(7'h4B, 8'h03, 1, 8'hA0, 8'h00, 1'b1, -1);

    // Reset while the target is pulling SDA low for a 0 bit of the ID byte.
    t_write(7'h4B, 8'h0B, 0, 8'h00, 8'h00, 1'b0, -1);
    m_hold = temp_in;
    m_start();
    m_wbyte({7'h4B, 1'b1}, 1'b0, "addr_ack_r", -1);
    m_hits++;
    m_rbit(b);
    m_rbit(b);
    sb_expect("oe_driving_zero", 16'd1); sb_observe({15'd0, sda_oe});
    #1 reset_n = 1'b0;
    #1;
    sb_expect("oe_async_reset", 16'd0);   sb_observe({15'd0, sda_oe});
    sb_expect("cfg_async_reset", 16'd0);  sb_observe({8'd0, cfg_reg});
    sb_expect("busy_async_reset", 16'd0); sb_observe({15'd0, busy});
    wt(2);
    scl_m = 1'b1; sda_m = 1'b1;
    wt(4);
    reset_n = 1'b1;
    wt(4);
    m_ptr = 8'h00;
    m_cfg = 8'h00;
    t_write(7'h4B, 8'h03, 1, 8'h5A, 8'h00, 1'b1, -1);

    // Pointer 0, repeated START, 2-byte read with temp_in changing mid-transfer.
    temp_in = 16'h0C80;
    t_write(7'h4B, 8'h00, 0, 8'h00, 8'h00, 1'b0, -1);
    t_read(2, 16'h1234);

    // Foreign address is ignored until STOP.
    t_write(7'h48, 8'h03, 0, 8'h00, 8'h00, 1'b1, -1);

    // Pointer wrap and ID register.
    temp_in = 16'h0C80;
    t_write(7'h4B, 8'hFF, 0, 8'h00, 8'h00, 1'b0, -1);
    t_read(2, 16'h5555);
    t_write(7'h4B, 8'h0B, 0, 8'h00, 8'h00, 1'b0, -1);
    t_read(1, 16'h5555);

`ifdef TMP_RESP_GLITCH_FILTER_EN
    t_write(7'h4B, 8'h03, 1, 8'h3C, 8'h00, 1'b1, 5);
`endif

    for (int t = 0; t < 16; t++) begin
      case ($urandom_range(0, 3))
        0: t_write(($urandom_range(0, 3) == 0) ? 7'h48 : 7'h4B, pick_ptr(), $urandom_range(0, 2),
                   8'($urandom), 8'($urandom), 1'b1, -1);
        1, 2: begin
          temp_in = 16'($urandom);
          t_write(7'h4B, pick_ptr(), 0, 8'h00, 8'h00, 1'b0, -1);
          t_read($urandom_range(1, 3), 16'($urandom));
        end
        default: begin
          temp_in = 16'($urandom);
          t_read($urandom_range(1, 3), 16'($urandom));
        end
      endcase
    end

    for (int i = 0; i < 200 && obs_q.size() > 0; i++) wt(1);
    wt(2);
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected and %0d observed entries left, required 0 and 0",
               exp_q.size(), obs_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
